// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready and tag passthrough
`timescale 1ns/1ps
module shift_pipe #(
   parameter int WIDTH      = 32,
   parameter int PIPE_EVERY = 2,
   parameter int TAG_W      = 4,
   localparam int LOG2W     = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [LOG2W-1:0] in_amt,
   input  logic [1:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_zero
);
   localparam int NSTG  = (LOG2W + PIPE_EVERY - 1) / PIPE_EVERY;
   // Leftover levels land in stage 0, so it may hold fewer than PIPE_EVERY.
   localparam int FIRST = LOG2W - (NSTG - 1) * PIPE_EVERY;

   logic             valid_q [NSTG];
   logic             valid_d [NSTG];
   logic [WIDTH-1:0] data_q  [NSTG];
   logic [WIDTH-1:0] data_d  [NSTG];
   logic [TAG_W-1:0] tag_q   [NSTG];
   logic [TAG_W-1:0] tag_d   [NSTG];
   logic [1:0]       op_q    [NSTG];
   logic [1:0]       op_d    [NSTG];
   logic [LOG2W-1:0] amt_q   [NSTG];
   logic [LOG2W-1:0] amt_d   [NSTG];
   logic             sign_q  [NSTG];
   logic             sign_d  [NSTG];

   logic             src_valid [NSTG];
   logic [WIDTH-1:0] src_data  [NSTG];
   logic [TAG_W-1:0] src_tag   [NSTG];
   logic [1:0]       src_op    [NSTG];
   logic [LOG2W-1:0] src_amt   [NSTG];
   logic             src_sign  [NSTG];
   logic             advance;

   function automatic int lvl_lo(input int s);
      return (s == 0) ? 0 : FIRST + (s - 1) * PIPE_EVERY;
   endfunction

   function automatic int lvl_hi(input int s);
      return FIRST + s * PIPE_EVERY;
   endfunction

   function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                    input logic [1:0] op,
                                                    input logic sign,
                                                    input int sh);
      logic [WIDTH-1:0] fill;
      logic [WIDTH-1:0] res;
      fill = sign ? ~({WIDTH{1'b1}} >> sh) : '0;
      case (op)
         2'b00:   res = d << sh;
         2'b01:   res = d >> sh;
         2'b10:   res = (d >> sh) | fill;
         default: res = (d >> sh) | (d << (WIDTH - sh));
      endcase
      return res;
   endfunction

   always_comb begin
      logic [WIDTH-1:0] shifted;
      advance      = out_ready | ~valid_q[NSTG-1];
      src_valid[0] = in_valid;
      src_data[0]  = in_data;
      src_tag[0]   = in_tag;
      src_op[0]    = in_op;
      src_amt[0]   = in_amt;
      src_sign[0]  = in_data[WIDTH-1];
      for (int s = 1; s < NSTG; s++) begin
         src_valid[s] = valid_q[s-1];
         src_data[s]  = data_q[s-1];
         src_tag[s]   = tag_q[s-1];
         src_op[s]    = op_q[s-1];
         src_amt[s]   = amt_q[s-1];
         src_sign[s]  = sign_q[s-1];
      end
      for (int s = 0; s < NSTG; s++) begin
         shifted = src_data[s];
         // Level k moves by WIDTH>>(k+1) and is keyed by amount bit LOG2W-1-k.
         for (int k = 0; k < LOG2W; k++) begin
            if (k >= lvl_lo(s) && k < lvl_hi(s) && src_amt[s][LOG2W-1-k])
               shifted = shift_level(shifted, src_op[s], src_sign[s], WIDTH >> (k + 1));
         end
         if (advance) begin
            valid_d[s] = src_valid[s];
            data_d[s]  = shifted;
            tag_d[s]   = src_tag[s];
            op_d[s]    = src_op[s];
            amt_d[s]   = src_amt[s];
            sign_d[s]  = src_sign[s];
         end else begin
            valid_d[s] = valid_q[s];
            data_d[s]  = data_q[s];
            tag_d[s]   = tag_q[s];
            op_d[s]    = op_q[s];
            amt_d[s]   = amt_q[s];
            sign_d[s]  = sign_q[s];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NSTG; s++) begin
            valid_q[s] <= 1'b0;
            data_q[s]  <= '0;
            tag_q[s]   <= '0;
            op_q[s]    <= '0;
            amt_q[s]   <= '0;
            sign_q[s]  <= 1'b0;
         end
      end else begin
         for (int s = 0; s < NSTG; s++) begin
            valid_q[s] <= valid_d[s];
            data_q[s]  <= data_d[s];
            tag_q[s]   <= tag_d[s];
            op_q[s]    <= op_d[s];
            amt_q[s]   <= amt_d[s];
            sign_q[s]  <= sign_d[s];
         end
      end
   end

   assign in_ready  = advance;
   assign out_valid = valid_q[NSTG-1];
   assign out_data  = data_q[NSTG-1];
   assign out_tag   = tag_q[NSTG-1];
   assign out_zero  = (data_q[NSTG-1] == '0);

endmodule

// File: tb/tb_shift_pipe.sv
// tb/tb_shift_pipe.sv - directed and randomized bench for shift_pipe against an arithmetic reference
`timescale 1ns/1ps
module tb_shift_pipe;
   localparam int L_A = 3;
   localparam int L_B = 3;
   localparam int L_C = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   edges = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) edges <= edges + 1;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_zero;
   logic [31:0] a_in_data, a_out_data;
   logic [4:0]  a_in_amt;
   logic [1:0]  a_in_op;
   logic [3:0]  a_in_tag, a_out_tag;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_zero;
   logic [7:0]  b_in_data, b_out_data;
   logic [2:0]  b_in_amt;
   logic [1:0]  b_in_op;
   logic [3:0]  b_in_tag, b_out_tag;

   logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_zero;
   logic [63:0] c_in_data, c_out_data;
   logic [5:0]  c_in_amt;
   logic [1:0]  c_in_op;
   logic [3:0]  c_in_tag, c_out_tag;

   shift_pipe #(.WIDTH(32), .PIPE_EVERY(2), .TAG_W(4)) u_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .in_amt(a_in_amt), .in_op(a_in_op), .in_tag(a_in_tag),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .out_tag(a_out_tag), .out_zero(a_out_zero));

   shift_pipe #(.WIDTH(8), .PIPE_EVERY(1), .TAG_W(4)) u_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .in_amt(b_in_amt), .in_op(b_in_op), .in_tag(b_in_tag),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_tag(b_out_tag), .out_zero(b_out_zero));

   shift_pipe #(.WIDTH(64), .PIPE_EVERY(6), .TAG_W(4)) u_c (
      .clk(clk), .rst_n(rst_n),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
      .in_amt(c_in_amt), .in_op(c_in_op), .in_tag(c_in_tag),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
      .out_tag(c_out_tag), .out_zero(c_out_zero));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Whole-amount shift on a w-bit value held in 64 bits.
   function automatic logic [63:0] ref_shift(input logic [63:0] din, input int amt,
                                             input logic [1:0] op, input int w);
      logic [63:0] mask, d, r;
      mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      d = din & mask;
      case (op)
         2'b00: r = (d << amt) & mask;
         2'b01: r = d >> amt;
         2'b10: r = (d >> amt) | (d[w-1] ? (mask & ~(mask >> amt)) : 64'd0);
         default: r = (amt == 0) ? d : (((d >> amt) | (d << (w - amt))) & mask);
      endcase
      return r;
   endfunction

   task automatic a_beat(input logic [31:0] d, input int amt, input logic [1:0] op,
                         input logic [3:0] tag, input logic [31:0] exp, input string name);
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      a_in_data   = d;
      a_in_amt    = amt[4:0];
      a_in_op     = op;
      a_in_tag    = tag;
      #1 check({name, " in_ready"}, a_in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      a_in_valid = 1'b0;
      for (int i = 0; i < L_A - 1; i++) begin
         check({name, " early valid"}, a_out_valid, 0);
         @(negedge clk);
      end
      check({name, " valid"}, a_out_valid, 1);
      check({name, " data"}, a_out_data, exp);
      check({name, " tag"}, a_out_tag, tag);
      check({name, " zero"}, a_out_zero, exp == 32'd0);
      @(negedge clk);
   endtask

   logic [63:0] bq_d[$], cq_d[$];
   int          bq_t[$], bq_e[$], cq_t[$], cq_e[$];
   logic [31:0] bp_exp [1:6];
   logic [31:0] bp_din [1:6];
   logic [4:0]  bp_amt [1:6];
   logic [1:0]  bp_op  [1:6];

   initial begin
      logic [31:0] rd;
      logic [31:0] frz_d;
      logic [3:0]  frz_t;
      logic [63:0] e;
      int          next_tag, exp_tag, stall_cycles, acc, ra;
      logic        frz_set;

      a_in_valid = 1'b1; a_in_data = 32'h1234_5678; a_in_amt = 5'd3; a_in_op = 2'b00;
      a_in_tag = 4'h5; a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_data = '0; b_in_amt = '0; b_in_op = '0; b_in_tag = '0;
      b_out_ready = 1'b1;
      c_in_valid = 1'b0; c_in_data = '0; c_in_amt = '0; c_in_op = '0; c_in_tag = '0;
      c_out_ready = 1'b1;

      repeat (3) @(negedge clk);
      check("rst out_valid", a_out_valid, 0);
      check("rst out_data", a_out_data, 0);
      check("rst out_zero", a_out_zero, 1);
      check("rst out_tag", a_out_tag, 0);
      check("rst b out_valid", b_out_valid, 0);
      check("rst c out_valid", c_out_valid, 0);
      rst_n = 1'b1;
      a_in_valid = 1'b0;
      @(negedge clk);
      check("post rst in_ready", a_in_ready, 1);
      check("post rst out_valid", a_out_valid, 0);

      a_beat(32'h8000_00F0, 4, 2'b00, 4'h1, 32'h0000_0F00, "sll4");
      a_beat(32'h8000_00F0, 4, 2'b01, 4'h2, 32'h0800_000F, "srl4");
      a_beat(32'h8000_00F0, 4, 2'b10, 4'h3, 32'hF800_000F, "sra4");
      a_beat(32'h8000_00F0, 4, 2'b11, 4'h4, 32'h0800_000F, "ror4");
      a_beat(32'h0000_000F, 4, 2'b11, 4'h5, 32'hF000_0000, "ror4 wrap");
      a_beat(32'h8000_0000, 31, 2'b10, 4'h6, 32'hFFFF_FFFF, "sra31");
      a_beat(32'h8000_0000, 31, 2'b01, 4'h7, 32'h0000_0001, "srl31");
      a_beat(32'h0000_0000, 9, 2'b00, 4'h8, 32'h0000_0000, "zero in");
      for (int op = 0; op < 4; op++) begin
         rd = $urandom;
         a_beat(rd, 0, op[1:0], 4'(op + 9), rd, "amt0");
      end
      for (int i = 0; i < 6; i++) begin
         rd = $urandom;
         ra = $urandom_range(0, 31);
         e  = ref_shift({32'd0, rd}, ra, 2'(i % 4), 32);
         a_beat(rd, ra, 2'(i % 4), 4'(i), e[31:0], "rand32");
      end

      // SLL 1 by 31 then by 0, back to back
      a_out_ready = 1'b1;
      a_in_valid = 1'b1; a_in_data = 32'h1; a_in_amt = 5'd31; a_in_op = 2'b00; a_in_tag = 4'h7;
      @(posedge clk); @(negedge clk);
      a_in_amt = 5'd0; a_in_tag = 4'h8;
      @(posedge clk); @(negedge clk);
      a_in_valid = 1'b0;
      check("b2b early", a_out_valid, 0);
      @(negedge clk);
      check("b2b first valid", a_out_valid, 1);
      check("b2b first data", a_out_data, 32'h8000_0000);
      check("b2b first tag", a_out_tag, 4'h7);
      @(negedge clk);
      check("b2b second valid", a_out_valid, 1);
      check("b2b second data", a_out_data, 32'h1);
      check("b2b second tag", a_out_tag, 4'h8);
      @(negedge clk);
      check("b2b drained", a_out_valid, 0);

      for (int t = 1; t <= 6; t++) begin
         bp_din[t] = $urandom;
         bp_amt[t] = 5'($urandom_range(0, 31));
         bp_op[t]  = 2'($urandom_range(0, 3));
         e = ref_shift({32'd0, bp_din[t]}, int'(bp_amt[t]), bp_op[t], 32);
         bp_exp[t] = e[31:0];
      end
      next_tag = 1; exp_tag = 1; stall_cycles = 0; frz_set = 1'b0;
      frz_d = '0; frz_t = '0;
      for (int c = 0; c < 40 && exp_tag <= 6; c++) begin
         a_out_ready = !(c >= 4 && c <= 7);
         if (next_tag <= 6) begin
            a_in_valid = 1'b1;
            a_in_data  = bp_din[next_tag];
            a_in_amt   = bp_amt[next_tag];
            a_in_op    = bp_op[next_tag];
            a_in_tag   = 4'(next_tag);
         end else begin
            a_in_valid = 1'b0;
         end
         #1;
         if (a_out_valid && !a_out_ready) begin
            stall_cycles++;
            check("bp stall in_ready", a_in_ready, 0);
            if (frz_set) begin
               check("bp frozen data", a_out_data, frz_d);
               check("bp frozen tag", a_out_tag, frz_t);
            end else begin
               frz_d = a_out_data; frz_t = a_out_tag; frz_set = 1'b1;
            end
         end
         if (a_out_valid && a_out_ready) begin
            check("bp tag order", a_out_tag, exp_tag);
            check("bp data", a_out_data, bp_exp[exp_tag]);
            exp_tag++;
         end
         acc = (a_in_valid && a_in_ready) ? 1 : 0;
         @(posedge clk);
         next_tag += acc;
         @(negedge clk);
      end
      check("bp all tags out", exp_tag, 7);
      check("bp stall cycles", stall_cycles, 4);
      a_in_valid = 1'b0; a_out_ready = 1'b1;
      @(negedge clk);
      check("bp no extra", a_out_valid, 0);

      // reset with three beats in flight
      for (int i = 0; i < 3; i++) begin
         a_in_valid = 1'b1; a_in_data = $urandom; a_in_amt = 5'd3; a_in_op = 2'b01;
         a_in_tag = 4'(9 + i);
         @(posedge clk); @(negedge clk);
      end
      a_in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst out_valid", a_out_valid, 0);
      check("midrst out_data", a_out_data, 0);
      check("midrst out_zero", a_out_zero, 1);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("midrst nothing emerges", a_out_valid, 0);
      end
      a_beat(32'h8000_0001, 1, 2'b10, 4'hC, 32'hC000_0000, "after midrst");

      // parameter sweep: WIDTH=8/PIPE_EVERY=1 and WIDTH=64/PIPE_EVERY=6
      for (int i = 0; i < 260; i++) begin
         if (b_out_valid) begin
            if (bq_d.size() == 0) check("b spurious out", b_out_valid, 0);
            else begin
               e = bq_d.pop_front();
               check("b data", b_out_data, e);
               check("b tag", b_out_tag, bq_t.pop_front());
               check("b zero", b_out_zero, e == 64'd0);
               check("b latency", edges - bq_e.pop_front(), L_B - 1);
            end
         end
         if (c_out_valid) begin
            if (cq_d.size() == 0) check("c spurious out", c_out_valid, 0);
            else begin
               e = cq_d.pop_front();
               check("c data", c_out_data, e);
               check("c tag", c_out_tag, cq_t.pop_front());
               check("c zero", c_out_zero, e == 64'd0);
               check("c latency", edges - cq_e.pop_front(), L_C - 1);
            end
         end
         if (i < 240) begin
            b_in_valid = ($urandom_range(0, 3) != 0);
            b_in_data  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            b_in_amt   = 3'($urandom_range(0, 7));
            b_in_op    = 2'($urandom_range(0, 3));
            b_in_tag   = 4'($urandom);
            c_in_valid = ($urandom_range(0, 3) != 0);
            c_in_data  = {$urandom, $urandom};
            c_in_amt   = 6'($urandom_range(0, 63));
            c_in_op    = 2'($urandom_range(0, 3));
            c_in_tag   = 4'($urandom);
         end else begin
            b_in_valid = 1'b0;
            c_in_valid = 1'b0;
         end
         #1;
         if (b_in_valid) begin
            check("b in_ready", b_in_ready, 1);
            bq_d.push_back(ref_shift({56'd0, b_in_data}, int'(b_in_amt), b_in_op, 8));
            bq_t.push_back(int'(b_in_tag));
            bq_e.push_back(edges + 1);
         end
         if (c_in_valid) begin
            check("c in_ready", c_in_ready, 1);
            cq_d.push_back(ref_shift(c_in_data, int'(c_in_amt), c_in_op, 64));
            cq_t.push_back(int'(c_in_tag));
            cq_e.push_back(edges + 1);
         end
         @(negedge clk);
      end
      check("b queue drained", bq_d.size(), 0);
      check("c queue drained", cq_d.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised, pipelined barrel shifter for the ALU datapath.
- Generalises the fixed 32-bit arithmetic-right shifter to:
  - any power-of-two width;
  - four shift modes (SLL, SRL, SRA, ROR);
  - configurable register insertion between log-shift levels;
  - valid/ready handshakes with a caller tag carried alongside the data.
- Sits between the operand-read stage and the ALU result mux. Multi-cycle shifts no longer limit the ALU clock period.

Parameters:
- WIDTH, 32, data width; power of two, 8..64.
- LOG2W, log2(WIDTH), shift-amount width and number of shift levels; derived, never overridden.
- PIPE_EVERY, 2, shift levels per pipeline register, 1..LOG2W.
  - Latency L = ceil(LOG2W/PIPE_EVERY).
  - Default gives L = 3.
- TAG_W, 4, width of the caller tag passed through unchanged.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  WIDTH  value to shift.
- in_amt  input  LOG2W  shift amount.
- in_op  input  2  mode select: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  input  TAG_W  caller tag.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result this cycle.
- out_data  output  WIDTH  shifted result.
- out_tag  output  TAG_W  tag of the beat that produced out_data.
- out_zero  output  1  out_data == 0.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, data, tag and op registers clear to 0.
  - Outputs during and after reset: out_valid=0, out_data=0, out_tag=0, out_zero=1.
  - in_ready=1 once rst_n is high.
  - Beats in flight when reset asserts are discarded; reset mid-operation produces no partial result.
- Shift levels:
  - Applied largest first: WIDTH/2, WIDTH/4, ..., 1.
  - Level k is enabled by in_amt bit (LOG2W-1-k) as carried down the pipe.
  - Each stage carries op and the remaining amount bits along with the data.
- Fill rules:
  - SLL fills zeros at the LSB.
  - SRL fills zeros at the MSB.
  - SRA fills copies of bit WIDTH-1 of the original operand. The sign is captured at input and carried, not re-read per level.
  - ROR wraps the bits shifted out of the LSB into the MSB.
- Amount 0: out_data equals in_data for every op.
- A pipeline register follows every PIPE_EVERY levels. The final register drives out_data, so outputs are registered.
  - Leftover levels (LOG2W not a multiple of PIPE_EVERY) go in the first stage.
- Pipeline advance: advance = out_ready | ~out_valid, one global enable for all stages.
  - in_ready = advance, purely combinational from out_ready and the last-stage valid.
  - Accept when in_valid & in_ready.
  - When advance=0, every stage holds; no data, valid or tag changes.
  - Bubbles are not collapsed while the last stage is stalled.
- Throughput and latency:
  - One beat per cycle when out_ready is held at 1.
  - A beat accepted at edge n appears with out_valid=1 after edge n+L-1 (L registers, L cycles of latency).
- out_valid and out_data must stay stable while out_valid=1 and out_ready=0.
- out_zero is computed from the final stage register; it is not an extra stage.
- Simultaneous accept and drain in the same cycle is legal; occupancy is unchanged.
- All arithmetic is WIDTH-bit. There is no overflow or carry output.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, out_data=0, out_zero=1. Release -> first result appears exactly L=3 cycles after the first accept.
- Modes, WIDTH=32, in_data=0x8000_00F0, amt=4:
  - SLL -> 0x0000_0F00
  - SRL -> 0x0800_000F
  - SRA -> 0xF800_000F
  - ROR -> 0x0800_000F
  - ROR of 0x0000_000F, amt=4 -> 0xF000_0000
- Boundary amounts:
  - SRA 0x8000_0000, amt=31 -> 0xFFFF_FFFF.
  - SRL same operand, amt=31 -> 0x0000_0001.
  - Any op with amt=0 -> input unchanged.
  - SLL 0x1, amt=31 then amt=0 back-to-back -> 0x8000_0000, then 0x1.
- Backpressure:
  - Stream tags 1..6 with out_ready low for cycles 4-7 -> in_ready=0 during the stall, outputs frozen.
  - Tags emerge in order 1..6 with none lost or duplicated.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight -> none emerge after release, and the next beat's result is correct.
- Parameter sweep: WIDTH=8/PIPE_EVERY=1 (L=3) and WIDTH=64/PIPE_EVERY=6 (L=1) -> random op/amt/data match a reference model and the latency formula.
